uart_tx_buffer: RTL and testbench

- Byte FIFO plus drain FSM that sits directly upstream of the `uart` transmitter.
- Producers (loopback logic, command responders, debug printers) push bytes in bursts without watching TX status.
- The block serialises them into the UART's tx_data_i / tx_trigger_i / tx_complete_o handshake, one byte per completed transmission.

---
 rtl/uart_tx_buffer.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_buffer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO with a drain FSM feeding the uart transmitter handshake.
// Producers push bytes without watching TX status; the FSM issues one
// tx_trigger_o pulse per byte and waits for the UART to finish each frame.
// Optional build macro: UART_TX_BUFFER_CRLF_EN inserts 0x0D ahead of every 0x0A.
module uart_tx_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned BUSY_WAIT  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [7:0]            wr_data_i,
    input  logic                  wr_en_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    input  logic                  overflow_clr_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_trigger_o,
    input  logic                  tx_complete_i
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]    BUSY_LAST = CNT_W'(BUSY_WAIT - 1);

    typedef enum logic [1:0] {StIdle, StTrig, StWaitBusy, StWaitDone} state_e;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  full_q, empty_q, overflow_q;
    logic [7:0]            tx_data_q;
    logic                  tx_trigger_q;
    logic [CNT_W-1:0]      busy_cnt_q;
    state_e                state_q;

    logic [7:0] head;
    logic       push, pop, start;

    assign head  = mem_q[rd_ptr_q];
    assign push  = wr_en_i && !full_q;
    // Launch a byte only when the UART reports idle and something is queued
    assign start = (state_q == StIdle) && !empty_q && tx_complete_i;

`ifdef UART_TX_BUFFER_CRLF_EN
    logic cr_flag_q;
    logic insert_cr;
    // A LF at the head is first announced by a CR that does not consume it
    assign insert_cr = start && (head == 8'h0A) && !cr_flag_q;
    assign pop       = start && !insert_cr;
`else
    assign pop = start;
`endif

    // Next occupancy; a simultaneous push and pop cancel out
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointers, occupancy flags and sticky overflow
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
            // Uses registered full, so a same-cycle pop does not rescue the write
            if (wr_en_i && full_q) begin
                overflow_q <= 1'b1;
            end else if (overflow_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    // Drain FSM with registered trigger and data outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= StIdle;
            tx_data_q    <= 8'h00;
            tx_trigger_q <= 1'b0;
            busy_cnt_q   <= '0;
`ifdef UART_TX_BUFFER_CRLF_EN
            cr_flag_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        tx_trigger_q <= 1'b1;
                        state_q      <= StTrig;
`ifdef UART_TX_BUFFER_CRLF_EN
                        if (insert_cr) begin
                            tx_data_q <= 8'h0D;
                            cr_flag_q <= 1'b1;
                        end else begin
                            tx_data_q <= head;
                            cr_flag_q <= 1'b0;
                        end
`else
                        tx_data_q <= head;
`endif
                    end
                end
                StTrig: begin
                    tx_trigger_q <= 1'b0;
                    busy_cnt_q   <= '0;
                    state_q      <= StWaitBusy;
                end
                StWaitBusy: begin
                    // A UART that never reports busy is assumed to have taken the byte
                    if (!tx_complete_i) begin
                        state_q <= StWaitDone;
                    end else if (busy_cnt_q == BUSY_LAST) begin
                        state_q <= StIdle;
                    end else begin
                        busy_cnt_q <= busy_cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (tx_complete_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign full_o       = full_q;
    assign empty_o      = empty_q;
    assign count_o      = count_q;
    assign overflow_o   = overflow_q;
    assign tx_data_o    = tx_data_q;
    assign tx_trigger_o = tx_trigger_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a small UART handshake model.
module tb_uart_tx_buffer;

    logic       clk_i = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [7:0] wr_data_i = 8'h00;
    logic       wr_en_i = 1'b0;
    logic       overflow_clr_i = 1'b0;
    logic       tx_complete_i;
    logic       full_o, empty_o, overflow_o, tx_trigger_o;
    logic [4:0] count_o;
    logic [7:0] tx_data_o;

    uart_tx_buffer #(
        .DEPTH_LOG2 (4),
        .BUSY_WAIT  (8)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .wr_data_i      (wr_data_i),
        .wr_en_i        (wr_en_i),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .overflow_clr_i (overflow_clr_i),
        .tx_data_o      (tx_data_o),
        .tx_trigger_o   (tx_trigger_o),
        .tx_complete_i  (tx_complete_i)
    );

    always #5 clk_i = ~clk_i;

    // UART model: 0 = manual level, 1 = drop after trigger for ~20 cycles, 2 = never busy
    int   mode = 0;
    logic tc_manual = 1'b1;
    logic model_tc = 1'b1;
    int   low_cnt = 0;
    assign tx_complete_i = (mode == 0) ? tc_manual : ((mode == 1) ? model_tc : 1'b1);

    always @(posedge clk_i) begin
        if (tx_trigger_o) begin
            model_tc <= 1'b0;
            low_cnt  <= 19;
        end else if (low_cnt > 0) begin
            low_cnt <= low_cnt - 1;
        end else begin
            model_tc <= 1'b1;
        end
    end

    // Monitor: log every triggered byte and the cycle it appeared in
    int         cyc = 0;
    int         trig_total = 0;
    int         dbl_pulse = 0;
    logic       prev_trig = 1'b0;
    logic [7:0] seen[$];
    int         seen_cyc[$];

    always @(posedge clk_i) begin
        cyc       <= cyc + 1;
        prev_trig <= tx_trigger_o;
        if (tx_trigger_o && prev_trig) dbl_pulse <= dbl_pulse + 1;
        if (rst_n_i && tx_trigger_o) begin
            seen.push_back(tx_data_o);
            seen_cyc.push_back(cyc);
            trig_total <= trig_total + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_data_i = b;
        wr_en_i   = 1'b1;
        tick();
        wr_en_i   = 1'b0;
    endtask

    int base;
    int snap;
    logic [7:0] exp_b;

    initial begin
        // Reset values
        #12;
        check_eq("rst_count", count_o, 0);
        check_eq("rst_empty", empty_o, 1);
        check_eq("rst_full", full_o, 0);
        check_eq("rst_ovf", overflow_o, 0);
        check_eq("rst_trig", tx_trigger_o, 0);
        check_eq("rst_data", tx_data_o, 8'h00);
        rst_n_i = 1'b1;
        tick();
        tick();

        // Single byte latency: trigger visible after E1, gone after E2
        push(8'h41);
        check_eq("e0_trig", tx_trigger_o, 0);
        check_eq("e0_count", count_o, 1);
        check_eq("e0_empty", empty_o, 0);
        tick();
        check_eq("e1_trig", tx_trigger_o, 1);
        check_eq("e1_data", tx_data_o, 8'h41);
        check_eq("e1_empty", empty_o, 1);
        tick();
        check_eq("e2_trig", tx_trigger_o, 0);
        check_eq("e2_data_hold", tx_data_o, 8'h41);
        repeat (12) tick();
        check_eq("one_trig", trig_total, 1);

        // Fill while UART busy, then overflow handling
        tc_manual = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        check_eq("fill_full", full_o, 1);
        check_eq("fill_count", count_o, 16);
        check_eq("fill_ovf", overflow_o, 0);
        check_eq("fill_no_trig", trig_total, 1);
        push(8'h20);
        check_eq("ovf_set", overflow_o, 1);
        check_eq("ovf_count", count_o, 16);
        overflow_clr_i = 1'b1;
        push(8'h20);
        check_eq("ovf_clr_vs_new", overflow_o, 1);
        tick();
        overflow_clr_i = 1'b0;
        check_eq("ovf_cleared", overflow_o, 0);

        // Drain through a UART that goes busy for ~20 cycles per byte
        base = seen.size();
        mode = 1;
        for (int i = 0; i < 1500 && (seen.size() - base) < 16; i++) tick();
        repeat (60) tick();
        check_eq("drain_n", seen.size() - base, 16);
        for (int i = 0; i < 16 && i < seen.size() - base; i++) begin
            exp_b = 8'(8'h10 + i);
            check_eq($sformatf("drain_b%0d", i), seen[base + i], exp_b);
        end
        check_eq("drain_empty", empty_o, 1);
        check_eq("drain_count", count_o, 0);

        // UART never reports busy: busy timeout gives a 10-cycle trigger period
        mode = 2;
        base = seen.size();
        push(8'hA1);
        push(8'hA2);
        check_eq("nb_trig1", tx_trigger_o, 1);
        repeat (5) tick();
        check_eq("nb_hold_data", tx_data_o, 8'hA1);
        check_eq("nb_hold_trig", tx_trigger_o, 0);
        repeat (25) tick();
        check_eq("nb_n", seen.size() - base, 2);
        if (seen.size() - base >= 2) begin
            check_eq("nb_b0", seen[base], 8'hA1);
            check_eq("nb_b1", seen[base + 1], 8'hA2);
            check_eq("nb_period", seen_cyc[base + 1] - seen_cyc[base], 10);
        end

        // Asynchronous reset while waiting for the UART with 5 bytes queued
        mode = 1;
        for (int i = 0; i < 6; i++) push(8'(8'hB0 + i));
        tick();
        tick();
        check_eq("wd_count", count_o, 5);
        check_eq("wd_data", tx_data_o, 8'hB0);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_eq("ar_count", count_o, 0);
        check_eq("ar_empty", empty_o, 1);
        check_eq("ar_data", tx_data_o, 8'h00);
        check_eq("ar_trig", tx_trigger_o, 0);
        mode = 2;
        tick();
        tick();
        #2;
        rst_n_i = 1'b1;
        snap = trig_total;
        repeat (40) tick();
        check_eq("ar_no_trig", trig_total - snap, 0);
        check_eq("ar_still_empty", empty_o, 1);

        // LF handling
        base = seen.size();
        push(8'h48);
        push(8'h0A);
        repeat (50) tick();
`ifdef UART_TX_BUFFER_CRLF_EN
        check_eq("lf_n", seen.size() - base, 3);
        if (seen.size() - base >= 3) begin
            check_eq("lf_b0", seen[base], 8'h48);
            check_eq("lf_b1", seen[base + 1], 8'h0D);
            check_eq("lf_b2", seen[base + 2], 8'h0A);
        end
`else
        check_eq("lf_n", seen.size() - base, 2);
        if (seen.size() - base >= 2) begin
            check_eq("lf_b0", seen[base], 8'h48);
            check_eq("lf_b1", seen[base + 1], 8'h0A);
        end
`endif
        check_eq("lf_empty", empty_o, 1);
        check_eq("single_cycle_pulses", dbl_pulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
